uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial transmitter that consumes the baud-rate square wave from the clock-generation block and the main logic clock.
- Accepts bytes over a valid/ready handshake and serialises them as 8N1-style frames on tx_o: start bit, data LSB first, optional parity, 1 or 2 stop bits.
- Sits between the FIFO read side and the board UART pin.
- Bit boundaries are the rising edges of baud_i, sampled in the clk_i domain; baud_i is derived from clk_i, so no synchroniser is needed.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- STOP_BITS, 1, number of stop bits (1 or 2).
- PARITY, 0, 0 = none, 1 = odd, 2 = even.

Ports:
- clk_i  input  1  main logic clock (clk_main).
- rst_i  input  1  synchronous, active-high reset.
- baud_i  input  1  baud square wave; each rising edge marks one bit period.
- data_i  input  DATA_BITS  byte to send.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block can accept data_i this cycle.
- tx_o  output  1  serial line, idle high.
- busy_o  output  1  frame in progress.

Behaviour:
- Clock/reset: one clock, clk_i; reset is synchronous, active-high, on rst_i.
- Reset values: tx_o=1, ready_o=1, busy_o=0, state=IDLE, baud_q=0, shift register=0, bit counter=0.
- Baud edge: baud_q <= baud_i every cycle; tick = baud_i & ~baud_q (combinational). All state advances happen only on tick cycles.
- Transfer: occurs when valid_i & ready_o in the same cycle; data_i is latched into the shift register.
- States: IDLE, ARMED, START, DATA, PARITY, STOP.
- IDLE:
  - ready_o=1, busy_o=0, tx_o=1.
  - Transfer -> ARMED.
  - A tick in the same cycle as the transfer does not start the frame.
- ARMED:
  - ready_o=0, busy_o=1, tx_o=1.
  - On tick -> START; tx_o=0 from the next cycle.
- START:
  - On tick -> DATA; tx_o = shift[0].
- DATA:
  - On each tick, shift right and increment the counter.
  - After DATA_BITS bits: go to PARITY if PARITY != 0, else STOP; tx_o updates accordingly.
  - Parity bit = XOR of the data bits (even), or its inverse (odd).
- STOP:
  - tx_o=1 for STOP_BITS bit periods.
  - ready_o=1 only during the final stop bit period.
  - On the tick ending the final stop bit:
    - if a byte was accepted during that stop period, or a transfer occurs on this same cycle -> START directly, with tx_o=0 next cycle (no idle gap);
    - otherwise -> IDLE.
- tx_o is registered. Its transition is visible on the clk_i cycle after the tick.
- Frame length: 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bit periods.
- Boundary cases:
  - valid_i while ready_o=0: ignored. The upstream holds data_i stable until the transfer.
  - data_i changing after the transfer: no effect on the frame in progress.
  - rst_i mid-frame: frame is aborted and the byte dropped; tx_o=1 and ready_o=1 on the next cycle.
  - baud_i stuck high or low: the FSM stalls in its current state, tx_o holds.
  - Illegal PARITY or STOP_BITS values: treated as 0 and 1 respectively.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, ARMED, START, DATA, PARITY, STOP);
  - PARITY_NONE / PARITY_ODD / PARITY_EVEN constants;
  - frame-length function.
- One sub-module, baud_edge: registers baud_i and outputs a one-cycle tick. It is reused by the future uart_rx.

Test Plan (all cases: baud_i square wave with a 16-clk period, 8 high / 8 low):
1. Reset held 3 cycles, then released -> tx_o=1, ready_o=1, busy_o=0; these values hold with no valid_i.
2. Send 0xA5, PARITY=0, STOP_BITS=1 -> after the next rising edge, tx_o = 0,1,0,1,0,0,1,0,1,1, each held 16 clks; ready_o low until the stop bit; busy_o returns to 0 after the stop bit.
3. Send 0x07 with PARITY=2 -> parity bit=1; with PARITY=1 -> parity bit=0; frame is 11 bit periods.
4. Send 0x55 then 0x0F with valid_i held high -> the second start bit begins exactly 16 clks after the first stop bit starts (no idle gap); both frames decode correctly.
5. rst_i pulsed during data bit 3 of 0xFF -> tx_o=1 and ready_o=1 the next cycle; a following 0x3C frame is correct.
6. STOP_BITS=2, send 0x00 -> tx_o low for 9 bit periods, then high for 32 clks; ready_o rises only for the last 16.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Frame length in bit periods.
    function automatic int frame_len(int data_bits, int parity, int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_edge.sv
// Rising-edge detector for the baud square wave; shared with the receiver.
module baud_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic baud_i,
    output logic tick_o
);

    logic baud_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) baud_q <= 1'b0;
        else       baud_q <= baud_i;
    end

    assign tick_o = baud_i & ~baud_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, start/data/parity/stop framing on tx_o.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 baud_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    // Out-of-range settings fall back to no parity and one stop bit.
    localparam int PAR_EFF  = (PARITY == PARITY_ODD || PARITY == PARITY_EVEN) ? PARITY : PARITY_NONE;
    localparam int STOP_EFF = (STOP_BITS == 2) ? 2 : 1;
    localparam bit ODD      = (PAR_EFF == PARITY_ODD);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_EFF - 1);

    state_t               state, state_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic [3:0]           cnt, cnt_d;
    logic                 tx, tx_d;
    logic                 par, par_d;
    logic                 pend, pend_d;
    logic                 tick, xfer, final_stop;

    baud_edge u_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .baud_i (baud_i),
        .tick_o (tick)
    );

    assign final_stop = (state == ST_STOP) && (cnt == LAST_STOP);
    assign ready_o    = (state == ST_IDLE) || (final_stop && !pend);
    assign busy_o     = (state != ST_IDLE);
    assign tx_o       = tx;
    assign xfer       = valid_i & ready_o;

    always_comb begin
        state_d = state;
        shift_d = shift;
        cnt_d   = cnt;
        tx_d    = tx;
        par_d   = par;
        pend_d  = pend;
        if (xfer) begin
            shift_d = data_i;
            par_d   = (^data_i) ^ ODD;
        end
        case (state)
            ST_IDLE:  if (xfer) state_d = ST_ARMED;
            ST_ARMED: if (tick) begin
                state_d = ST_START;
                tx_d    = 1'b0;
            end
            ST_START: if (tick) begin
                state_d = ST_DATA;
                tx_d    = shift[0];
                shift_d = shift >> 1;
                cnt_d   = '0;
            end
            ST_DATA: if (tick) begin
                if (cnt == LAST_DATA) begin
                    cnt_d = '0;
                    if (PAR_EFF != PARITY_NONE) begin
                        state_d = ST_PARITY;
                        tx_d    = par;
                    end else begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt + 4'd1;
                    tx_d    = shift[0];
                    shift_d = shift >> 1;
                end
            end
            ST_PARITY: if (tick) begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
            end
            ST_STOP: begin
                // A byte taken during the last stop bit chains straight into the next start bit.
                if (xfer) pend_d = 1'b1;
                if (tick) begin
                    if (cnt != LAST_STOP) begin
                        cnt_d = cnt + 4'd1;
                    end else begin
                        cnt_d  = '0;
                        pend_d = 1'b0;
                        if (pend || xfer) begin
                            state_d = ST_START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            shift <= '0;
            cnt   <= '0;
            tx    <= 1'b1;
            par   <= 1'b0;
            pend  <= 1'b0;
        end else begin
            state <= state_d;
            shift <= shift_d;
            cnt   <= cnt_d;
            tx    <= tx_d;
            par   <= par_d;
            pend  <= pend_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line waveform is built per frame from the framing rules.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    logic       stuck_en = 1'b0;
    logic       stuck_val = 1'b0;
    logic       baud;
    logic [7:0] data = 8'h00;
    logic [5:0] valid = '0;
    wire  [5:0] tx, ready, busy;

    int checks = 0;
    int errors = 0;

    // Effective settings per instance (instance 4 has illegal PARITY/STOP_BITS).
    int db[6] = '{8, 8, 8, 8, 8, 5};
    int pm[6] = '{0, 2, 1, 0, 0, 2};
    int sb[6] = '{1, 1, 1, 2, 1, 1};

    logic [7:0] bq[$];
    bit         eq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign baud = stuck_en ? stuck_val : cyc[3];

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) u0 (.clk_i(clk), .rst_i(rst), .baud_i(baud), .data_i(data),
        .valid_i(valid[0]), .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]));
    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2)) u1 (.clk_i(clk), .rst_i(rst), .baud_i(baud), .data_i(data),
        .valid_i(valid[1]), .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]));
    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(1)) u2 (.clk_i(clk), .rst_i(rst), .baud_i(baud), .data_i(data),
        .valid_i(valid[2]), .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]));
    uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(0)) u3 (.clk_i(clk), .rst_i(rst), .baud_i(baud), .data_i(data),
        .valid_i(valid[3]), .ready_o(ready[3]), .tx_o(tx[3]), .busy_o(busy[3]));
    uart_tx #(.DATA_BITS(8), .STOP_BITS(3), .PARITY(3)) u4 (.clk_i(clk), .rst_i(rst), .baud_i(baud), .data_i(data),
        .valid_i(valid[4]), .ready_o(ready[4]), .tx_o(tx[4]), .busy_o(busy[4]));
    uart_tx #(.DATA_BITS(5), .STOP_BITS(1), .PARITY(2)) u5 (.clk_i(clk), .rst_i(rst), .baud_i(baud), .data_i(data[4:0]),
        .valid_i(valid[5]), .ready_o(ready[5]), .tx_o(tx[5]), .busy_o(busy[5]));

    // Reference frame: start 0, data LSB first, optional parity, stop 1s.
    function automatic void add_frame(input int idx, input logic [7:0] d);
        int ones = 0;
        eq.push_back(1'b0);
        for (int i = 0; i < db[idx]; i++) begin
            eq.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pm[idx] == 2) eq.push_back(bit'(ones % 2));
        else if (pm[idx] == 1) eq.push_back(bit'(1 - ones % 2));
        for (int i = 0; i < sb[idx]; i++) eq.push_back(1'b1);
    endfunction

    // Sends every byte in bq on instance idx with valid held until each is taken,
    // then checks every cycle of the line against the concatenated reference frames.
    task automatic run(input int idx, input string name, input int align, input bit junk);
        int total, c_s, c_v, dly, j, lim, k, b;
        bit adv, done;
        eq.delete();
        foreach (bq[i]) add_frame(idx, bq[i]);
        total = eq.size();
        @(negedge clk);
        if (align >= 0)
            for (int w = 0; w < 16 && (cyc % 16) != align; w++) @(negedge clk);
        j = 0; adv = 0; done = 0; c_s = -1; c_v = 0; b = 0;
        data = bq[0];
        valid[idx] = 1'b1;
        lim = total * 16 + 120;
        for (int it = 0; it < lim && !done; it++) begin
            if (adv) begin
                adv = 0;
                j++;
                if (j < bq.size()) data = bq[j];
                else begin
                    data = 8'($urandom);
                    valid[idx] = junk;
                end
            end
            if (junk && c_s >= 0 && cyc >= c_s + 16) valid[idx] = 1'b0;
            if (c_s >= 0) begin
                if (cyc == c_s - 1) begin
                    checks++;
                    if (tx[idx] !== 1'b1) begin
                        errors++;
                        $display("FAIL %s idle_before_start cyc %0d: tx=%b expected 1", name, cyc, tx[idx]);
                    end
                end else if (cyc >= c_s) begin
                    k = cyc - c_s;
                    b = k / 16;
                    if (k < total * 16) begin
                        checks++;
                        if (tx[idx] !== eq[b] || busy[idx] !== 1'b1) begin
                            errors++;
                            $display("FAIL %s line bit %0d cyc %0d: tx=%b busy=%b expected tx=%b busy=1",
                                     name, b, k, tx[idx], busy[idx], eq[b]);
                        end
                        if (bq.size() == 1) begin
                            checks++;
                            if (ready[idx] !== (b == total - 1)) begin
                                errors++;
                                $display("FAIL %s ready bit %0d cyc %0d: ready=%b expected %b",
                                         name, b, k, ready[idx], (b == total - 1));
                            end
                        end
                    end else begin
                        checks++;
                        if ({tx[idx], busy[idx], ready[idx]} !== 3'b101) begin
                            errors++;
                            $display("FAIL %s after_frame: tx=%b busy=%b ready=%b expected tx=1 busy=0 ready=1",
                                     name, tx[idx], busy[idx], ready[idx]);
                        end
                        done = 1;
                    end
                end
            end
            if (valid[idx] && ready[idx] && j < bq.size()) begin
                if (j == 0) begin
                    // First tick strictly after the transfer cycle; line drops the cycle after it.
                    c_v = cyc;
                    dly = (8 - (c_v % 16) + 16) % 16;
                    if (dly == 0) dly = 16;
                    c_s = c_v + dly + 1;
                end
                adv = 1;
            end
            if (!done) @(negedge clk);
        end
        valid[idx] = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: frame not completed, start_cyc=%0d expected completion within %0d cycles", name, c_s, lim);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 6'h3F || ready !== 6'h3F || busy !== 6'h00) begin
            errors++;
            $display("FAIL reset_held: tx=%h ready=%h busy=%h expected 3f 3f 00", tx, ready, busy);
        end
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            checks++;
            if (tx !== 6'h3F || ready !== 6'h3F || busy !== 6'h00) begin
                errors++;
                $display("FAIL reset_idle: tx=%h ready=%h busy=%h expected 3f 3f 00", tx, ready, busy);
            end
        end
    endtask

    task automatic test_basic();
        bq = '{8'hA5};
        run(0, "a5_8n1", -1, 1'b0);
        repeat (3) begin
            bq = '{8'($urandom)};
            run(0, "rand_8n1_junk", int'($urandom_range(0, 15)), 1'b1);
        end
    endtask

    task automatic test_parity();
        bq = '{8'h07};
        run(1, "07_even", -1, 1'b0);
        run(2, "07_odd", -1, 1'b0);
        repeat (2) begin
            bq = '{8'($urandom)};
            run(1, "rand_even", int'($urandom_range(0, 15)), 1'b0);
            run(2, "rand_odd", int'($urandom_range(0, 15)), 1'b0);
            run(4, "rand_illegal_cfg", int'($urandom_range(0, 15)), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        bq = '{8'h55, 8'h0F};
        run(0, "b2b_55_0f", -1, 1'b0);
        bq = '{8'($urandom), 8'($urandom), 8'($urandom)};
        run(1, "b2b_rand_even", -1, 1'b0);
        bq = '{8'($urandom), 8'($urandom)};
        run(3, "b2b_rand_2stop", -1, 1'b0);
    endtask

    task automatic test_tick_collision();
        bq = '{8'($urandom)};
        run(0, "xfer_on_tick", 8, 1'b0);
        bq = '{8'($urandom)};
        run(2, "xfer_on_tick_odd", 8, 1'b0);
    endtask

    task automatic test_reset_midframe();
        bit seen = 0;
        @(negedge clk);
        data = 8'hFF;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        for (int w = 0; w < 40 && !seen; w++) begin
            @(negedge clk);
            if (tx[0] === 1'b0) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_mid start_timeout: tx=%b expected 0 within 40 cycles", tx[0]);
        end
        repeat (16 * 4 + 8) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1 || tx[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid in_frame: busy=%b tx=%b expected busy=1 tx=1", busy[0], tx[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({tx[0], ready[0], busy[0]} !== 3'b110) begin
            errors++;
            $display("FAIL rst_mid after_reset: tx=%b ready=%b busy=%b expected 1 1 0", tx[0], ready[0], busy[0]);
        end
        bq = '{8'h3C};
        run(0, "3c_after_reset", -1, 1'b0);
    endtask

    task automatic test_two_stop();
        bq = '{8'h00};
        run(3, "00_2stop", -1, 1'b0);
        bq = '{8'($urandom)};
        run(3, "rand_2stop", int'($urandom_range(0, 15)), 1'b1);
    endtask

    task automatic test_data5();
        repeat (2) begin
            bq = '{8'($urandom)};
            run(5, "rand_5e1", int'($urandom_range(0, 15)), 1'b0);
        end
    endtask

    // Freeze baud at its current level (high or low) during the start bit: line must hold.
    task automatic test_stuck_baud(input int pre);
        bit seen = 0;
        @(negedge clk);
        data = 8'($urandom);
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        for (int w = 0; w < 40 && !seen; w++) begin
            @(negedge clk);
            if (tx[0] === 1'b0) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stuck start_timeout: tx=%b expected 0 within 40 cycles", tx[0]);
        end
        repeat (pre) @(negedge clk);
        stuck_val = baud;
        stuck_en  = 1'b1;
        repeat (100) begin
            @(negedge clk);
            checks++;
            if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL stuck_baud_%0b hold: tx=%b busy=%b expected tx=0 busy=1", stuck_val, tx[0], busy[0]);
            end
        end
        stuck_en = 1'b0;
        seen = 0;
        for (int w = 0; w < 400 && !seen; w++) begin
            @(negedge clk);
            if (busy[0] === 1'b0) seen = 1;
        end
        checks++;
        if (!seen || tx[0] !== 1'b1 || ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL stuck_resume: done=%b tx=%b ready=%b expected 1 1 1", seen, tx[0], ready[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_tick_collision();
        test_reset_midframe();
        test_two_stop();
        test_data5();
        test_stuck_baud(0);
        test_stuck_baud(8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule
